// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master slice: FSM state encoding,
// SPI mode constants and the default word length / clock divider.
package spi_pkg;

  localparam int DEFAULT_BITS    = 8;
  localparam int DEFAULT_CLK_DIV = 2;

  // Mode encoding is {CPOL, CPHA}; only CPHA=0 modes are supported.
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE2 = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } spi_state_t;

  // Clock polarity bit of a mode constant.
  function automatic logic mode_cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/spi_clk_tick.sv
// Half-period tick generator for the SPI master. Counts 0..CLK_DIV-1 while
// enabled and emits a one-cycle tick on the last count; held at zero when
// the master is idle so every transfer starts from a clean phase.
module spi_clk_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = enable && (count == CNT_MAX);

  // Divider counter: wraps on each tick, cleared whenever the master is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!enable || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, one transfer per accepted
// start. Transfer phases: IDLE -> LEAD -> XFER -> TRAIL -> IDLE, each phase
// step paced by spi_clk_tick. miso is sampled on the leading sclk edge and
// mosi advances on the trailing edge.
// Optional feature: define SPI_MASTER_CPOL_EN to add a cpol input captured
// at accept; cpol=1 inverts every sclk level (mode 2) and sclk idles at the
// last captured polarity.
module spi_master
  import spi_pkg::*;
#(
  parameter int BITS    = DEFAULT_BITS,
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [BITS-1:0] tx_data,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] rx_data,
  output logic            sclk,
  output logic            ss_n,
  output logic            mosi,
  input  logic            miso
`ifdef SPI_MASTER_CPOL_EN
  ,
  input  logic            cpol
`endif
);

  localparam int EDGE_W = $clog2(2 * BITS + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * BITS - 1);

  spi_state_t state;
  spi_state_t state_next;

  logic              run;
  logic              tick;
  logic              accept;
  logic              rise_edge;
  logic              fall_edge;
  logic              last_fall;
  logic              finish;
  logic [EDGE_W-1:0] edge_cnt;
  logic [BITS-1:0]   tx_shift;
  logic [BITS-1:0]   rx_shift;
  logic              cpol_q;
  logic              cpol_load;

  assign run  = (state != IDLE);
  assign mosi = tx_shift[BITS-1];

  spi_clk_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(run),
    .tick  (tick)
  );

`ifdef SPI_MASTER_CPOL_EN
  assign cpol_load = mode_cpol(cpol ? SPI_MODE2 : SPI_MODE0);

  // Polarity is latched per transfer so sclk keeps that idle level afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpol_q <= 1'b0;
    end else if (accept) begin
      cpol_q <= cpol_load;
    end
  end
`else
  assign cpol_load = mode_cpol(SPI_MODE0);
  assign cpol_q    = cpol_load;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; the LEAD-ending tick is also the first leading sclk edge.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)     state_next = LEAD;
      LEAD:    if (tick)      state_next = XFER;
      XFER:    if (last_fall) state_next = TRAIL;
      TRAIL:   if (tick)      state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Per-cycle strobes; edge_cnt parity tells which sclk edge is next in XFER.
  always_comb begin
    accept    = 1'b0;
    rise_edge = 1'b0;
    fall_edge = 1'b0;
    last_fall = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE:  accept    = start;
      LEAD:  rise_edge = tick;
      XFER: begin
        rise_edge = tick && !edge_cnt[0];
        fall_edge = tick && edge_cnt[0];
        last_fall = tick && edge_cnt[0] && (edge_cnt == LAST_EDGE);
      end
      TRAIL: finish    = tick;
      default: ;
    endcase
  end

  // Datapath and registered SPI pins, driven by the strobes above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_n     <= 1'b1;
      sclk     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      edge_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        tx_shift <= tx_data;
        rx_shift <= '0;
        edge_cnt <= '0;
        ss_n     <= 1'b0;
        busy     <= 1'b1;
        sclk     <= cpol_load;
      end
      if (rise_edge) begin
        sclk     <= ~cpol_q;
        rx_shift <= {rx_shift[BITS-2:0], miso};
        edge_cnt <= edge_cnt + EDGE_W'(1);
      end
      if (fall_edge) begin
        sclk     <= cpol_q;
        edge_cnt <= edge_cnt + EDGE_W'(1);
        if (!last_fall) begin
          tx_shift <= {tx_shift[BITS-2:0], 1'b0};
        end
      end
      if (finish) begin
        ss_n    <= 1'b1;
        busy    <= 1'b0;
        done    <= 1'b1;
        rx_data <= rx_shift;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: three instances (CLK_DIV 2, 1, 5, BITS 8)
// share clock and reset. A small mode-0/2 slave model drives miso; expected
// words and completion cycles are hand-computed constants.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start;
  logic [2:0] busy;
  logic [2:0] done;
  logic [2:0] sclk;
  logic [2:0] ss_n;
  logic [2:0] mosi;
  logic [2:0] miso;
  logic [7:0] tx_data [3];
  logic [7:0] rx_data [3];
`ifdef SPI_MASTER_CPOL_EN
  logic [2:0] cpol;
`endif

  int total = 0;
  int bad   = 0;

  // Free-running system clock, 10 time units per cycle.
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    spi_master #(
      .BITS   (8),
      .CLK_DIV(g == 0 ? 2 : (g == 1 ? 1 : 5))
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start[g]),
      .tx_data(tx_data[g]),
      .busy   (busy[g]),
      .done   (done[g]),
      .rx_data(rx_data[g]),
      .sclk   (sclk[g]),
      .ss_n   (ss_n[g]),
      .mosi   (mosi[g]),
      .miso   (miso[g])
`ifdef SPI_MASTER_CPOL_EN
      ,
      .cpol   (cpol[g])
`endif
    );
  end

  // Every comparison funnels through here so the counts stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  // Runs one transfer on instance idx with a slave model (or loopback) on
  // miso, recording mosi at leading edges, edge spacing, busy and done.
  task automatic applyStimulus(input int idx, input int div, input logic [7:0] tx,
                               input logic [7:0] word, input bit loopback,
                               input bit cpolV, input int expDone,
                               input logic [7:0] expRx, input string name);
    int c, doneCycle, busyCount, busyFirst, rises, halfBad, lastToggle, sbit, doneCount;
    logic [7:0] mosiBits;
    logic [7:0] rxSeen;
    logic prevSclk, prevSs;
    @(negedge clk);
    tx_data[idx] = tx;
    start[idx]   = 1'b1;
`ifdef SPI_MASTER_CPOL_EN
    cpol[idx] = cpolV;
`endif
    prevSclk = sclk[idx];
    prevSs = ss_n[idx];
    c = 0; doneCycle = -1; busyCount = 0; busyFirst = -1; rises = 0;
    halfBad = 0; lastToggle = 0; sbit = 7; doneCount = 0;
    mosiBits = '0; rxSeen = '0;
    miso[idx] = 1'b0;
    while (c < 40 * div) begin
      @(negedge clk);
      c++;
      start[idx] = 1'b0;
      if (busy[idx]) begin
        busyCount++;
        if (busyFirst < 0) busyFirst = c;
      end
      if (done[idx]) begin
        doneCount++;
        if (doneCycle < 0) begin
          doneCycle = c;
          rxSeen = rx_data[idx];
        end
      end
      if (!ss_n[idx] && prevSs) begin
        miso[idx] = word[7];
        sbit = 6;
        lastToggle = c;
      end else if (!ss_n[idx] && !prevSs && sclk[idx] !== prevSclk) begin
        if (c - lastToggle != div) halfBad++;
        lastToggle = c;
        if (sclk[idx] == ~cpolV) begin
          rises++;
          mosiBits = {mosiBits[6:0], mosi[idx]};
        end else if (sbit >= 0) begin
          miso[idx] = word[sbit[2:0]];
          sbit--;
        end
      end
      if (loopback) miso[idx] = mosi[idx];
      prevSclk = sclk[idx];
      prevSs = ss_n[idx];
      if (doneCycle >= 0 && c >= doneCycle + 2) break;
    end
    checkOutput({name, "_done_cycle"}, doneCycle, expDone);
    checkOutput({name, "_rx"}, 32'(rxSeen), 32'(expRx));
    checkOutput({name, "_mosi_bits"}, 32'(mosiBits), 32'(tx));
    checkOutput({name, "_lead_edges"}, rises, 8);
    checkOutput({name, "_half_period"}, halfBad, 0);
    checkOutput({name, "_busy_first"}, busyFirst, 1);
    checkOutput({name, "_busy_cycles"}, busyCount, expDone - 1);
    checkOutput({name, "_done_pulses"}, doneCount, 1);
    checkOutput({name, "_idle_sclk"}, 32'(sclk[idx]), 32'(cpolV));
    checkOutput({name, "_idle_ss_n"}, 32'(ss_n[idx]), 1);
  endtask

  // Safety net in case a wait above somehow never returns.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main directed sequence.
  initial begin
    int c, dones, d1, d2, ssHigh, lateBusy, dn;
    logic [7:0] rx1, rx2;
    rst_n = 1'b0;
    start = '0;
    miso  = '0;
    for (int i = 0; i < 3; i++) tx_data[i] = '0;
`ifdef SPI_MASTER_CPOL_EN
    cpol = '0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("reset_ss_n", 32'(ss_n[0]), 1);
    checkOutput("reset_sclk", 32'(sclk[0]), 0);
    checkOutput("reset_busy", 32'(busy[0]), 0);
    checkOutput("reset_done", 32'(done[0]), 0);
    checkOutput("reset_mosi", 32'(mosi[0]), 0);
    checkOutput("reset_rx", 32'(rx_data[0]), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] basic transfer C5 / slave 65");
    applyStimulus(0, 2, 8'hC5, 8'h65, 1'b0, 1'b0, 35, 8'h65, "m0");

    $display("[TB] loopback A3");
    applyStimulus(0, 2, 8'hA3, 8'h00, 1'b1, 1'b0, 35, 8'hA3, "loop");

    $display("[TB] back-to-back with start held high");
    @(negedge clk);
    tx_data[0] = 8'h0F;
    start[0] = 1'b1;
    c = 0; dones = 0; d1 = -1; d2 = -1; ssHigh = 0; lateBusy = 0;
    rx1 = '0; rx2 = '0;
    while (c < 100) begin
      @(negedge clk);
      c++;
      miso[0] = mosi[0];
      if (c == 10) tx_data[0] = 8'hFF;
      if (c == 40) start[0] = 1'b0;
      if (c == 50) start[0] = 1'b1;
      if (c == 51) start[0] = 1'b0;
      if (c >= 30 && c <= 45 && ss_n[0]) ssHigh++;
      if (c > 70 && busy[0]) lateBusy++;
      if (done[0]) begin
        dones++;
        if (d1 < 0) begin
          d1 = c;
          rx1 = rx_data[0];
          tx_data[0] = 8'hF0;
        end else if (d2 < 0) begin
          d2 = c;
          rx2 = rx_data[0];
        end
      end
    end
    checkOutput("b2b_first_done", d1, 35);
    checkOutput("b2b_second_done", d2, 70);
    checkOutput("b2b_first_rx", 32'(rx1), 32'h0F);
    checkOutput("b2b_second_rx", 32'(rx2), 32'hF0);
    checkOutput("b2b_gap_ss_high", ssHigh, 1);
    checkOutput("b2b_done_count", dones, 2);
    checkOutput("b2b_busy_after", lateBusy, 0);

    $display("[TB] reset in the middle of XFER");
    @(negedge clk);
    tx_data[0] = 8'h3C;
    start[0] = 1'b1;
    miso[0] = 1'b1;
    repeat (16) begin
      @(negedge clk);
      start[0] = 1'b0;
    end
    checkOutput("midrst_pre_busy", 32'(busy[0]), 1);
    checkOutput("midrst_pre_sclk", 32'(sclk[0]), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ss_n", 32'(ss_n[0]), 1);
    checkOutput("midrst_sclk", 32'(sclk[0]), 0);
    checkOutput("midrst_busy", 32'(busy[0]), 0);
    checkOutput("midrst_rx", 32'(rx_data[0]), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done[0] || busy[0]) dn++;
    end
    checkOutput("midrst_no_done", dn, 0);
    checkOutput("midrst_rx_after", 32'(rx_data[0]), 0);
    miso[0] = 1'b0;
    applyStimulus(0, 2, 8'h5A, 8'h81, 1'b0, 1'b0, 35, 8'h81, "post_rst");

    $display("[TB] divider extremes");
    applyStimulus(1, 1, 8'hFF, 8'h3C, 1'b0, 1'b0, 18, 8'h3C, "div1");
    applyStimulus(2, 5, 8'h00, 8'hC3, 1'b0, 1'b0, 86, 8'hC3, "div5");

`ifdef SPI_MASTER_CPOL_EN
    $display("[TB] mode 2 transfer");
    applyStimulus(0, 2, 8'hC5, 8'h65, 1'b0, 1'b1, 35, 8'h65, "cpol1");
    repeat (3) @(negedge clk);
    checkOutput("cpol1_idle_high", 32'(sclk[0]), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
